// File: rtl/rcfwl_gclk_clkreqaggr_pkg.sv
// Clock-request aggregator shared types.
// FSM state encoding and default parameter constants.
package rcfwl_gclk_clkreqaggr_pkg;

  localparam int DEF_LINGER_W   = 8;
  localparam int DEF_RST_LINGER = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_ACTIVE   = 3'd2,
    S_LINGER   = 3'd3,
    S_DEASSERT = 3'd4
  } state_t;

endpackage

// File: rtl/rcfwl_gclk_clkreqaggr_mc_if.sv
// Downstream/upstream clkreq/clkack handshake bundle.
// master: consumer/source side; slave: aggregator side.
interface rcfwl_gclk_clkreqaggr_mc_if #(
  parameter int NUM_CH = 4
);

  logic [NUM_CH-1:0] ch_clkreq;
  logic [NUM_CH-1:0] ch_clkack;
  logic              up_clkreq;
  logic              up_clkack;

  modport master (
    output ch_clkreq,
    input  ch_clkack,
    input  up_clkreq,
    output up_clkack
  );

  modport slave (
    input  ch_clkreq,
    output ch_clkack,
    output up_clkreq,
    input  up_clkack
  );

endinterface

// File: rtl/rcfwl_gclk_linger_cnt.sv
// Loadable linger down-counter; clr > load > dec.
// Ports: clk, rst, load, dec, clr, load_val in; expire (cnt==1) out.
module rcfwl_gclk_linger_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic         clr,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = (cnt == W'(1));

endmodule

// File: rtl/rcfwl_gclk_clkreqaggr_mc.sv
// Multi-channel clkreq aggregator with mask, linger and ack-drop flag.
// Ports: clk, rst, cfg_linger(_vld), ch_mask, hs (handshakes), status.
module rcfwl_gclk_clkreqaggr_mc
  import rcfwl_gclk_clkreqaggr_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int LINGER_W   = DEF_LINGER_W,
  parameter int RST_LINGER = DEF_RST_LINGER
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LINGER_W-1:0] cfg_linger,
  input  logic                cfg_linger_vld,
  input  logic [NUM_CH-1:0]   ch_mask,
  rcfwl_gclk_clkreqaggr_mc_if.slave hs,
  output logic                agg_active,
  output logic                err_ack_drop,
  output logic [2:0]          state_o
);

  localparam logic [LINGER_W-1:0] RST_LV = LINGER_W'(RST_LINGER);

  state_t              st;
  state_t              nxt;
  logic [NUM_CH-1:0]   live;
  logic                req_any;
  logic [LINGER_W-1:0] linger_val;
  logic                ld;
  logic                dec;
  logic                clr;
  logic                expire;
  logic                err_set;
  logic [NUM_CH-1:0]   ack_d;
  logic [NUM_CH-1:0]   ack_q;
  logic                up_q;

  assign live       = hs.ch_clkreq & ~ch_mask;
  assign req_any    = |live;
  assign linger_val = cfg_linger_vld ? cfg_linger : RST_LV;

  always_comb begin
    nxt     = st;
    ld      = 1'b0;
    dec     = 1'b0;
    clr     = 1'b0;
    err_set = 1'b0;
    ack_d   = '0;
    unique case (st)
      S_IDLE: begin
        if (req_any) nxt = S_REQ;
      end
      S_REQ: begin
        if (hs.up_clkack) nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (!hs.up_clkack) begin
          nxt     = S_REQ;
          err_set = 1'b1;
        end else begin
          ack_d = live;
          if (!req_any) begin
            if (linger_val != '0) begin
              nxt = S_LINGER;
              ld  = 1'b1;
            end else begin
              nxt = S_DEASSERT;
            end
          end
        end
      end
      S_LINGER: begin
        if (!hs.up_clkack) begin
          nxt     = S_REQ;
          err_set = 1'b1;
          clr     = 1'b1;
        end else begin
          ack_d = live;
          if (req_any) begin
            nxt = S_ACTIVE;
            clr = 1'b1;
          end else if (expire) begin
            nxt = S_DEASSERT;
            clr = 1'b1;
          end else begin
            dec = 1'b1;
          end
        end
      end
      S_DEASSERT: begin
        if (!hs.up_clkack) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= S_IDLE;
      up_q         <= 1'b0;
      agg_active   <= 1'b0;
      err_ack_drop <= 1'b0;
      ack_q        <= '0;
    end else begin
      st           <= nxt;
      up_q         <= (nxt == S_REQ) || (nxt == S_ACTIVE)
                      || (nxt == S_LINGER);
      agg_active   <= (nxt == S_ACTIVE) || (nxt == S_LINGER);
      err_ack_drop <= err_ack_drop | err_set;
      ack_q        <= ack_d;
    end
  end

  rcfwl_gclk_linger_cnt #(
    .W (LINGER_W)
  ) u_linger_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .dec      (dec),
    .clr      (clr),
    .load_val (linger_val),
    .expire   (expire)
  );

  assign hs.up_clkreq = up_q;
  assign hs.ch_clkack = ack_q;
  assign state_o      = st;

endmodule

// File: tb/tb_rcfwl_gclk_clkreqaggr_mc.sv
// Bench for rcfwl_gclk_clkreqaggr_mc.
// Directed scenarios with literal pins, then random traffic vs model.
module tb_rcfwl_gclk_clkreqaggr_mc;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cfg_linger;
  logic       cfg_linger_vld;
  logic [N-1:0] ch_mask;
  logic       agg_active;
  logic       err_ack_drop;
  logic [2:0] state_o;

  int checks = 0;
  int failures = 0;

  // model state: phase 0..4 and linger cycles remaining
  int         m_ph;
  int         m_rem;
  logic       m_up;
  logic       m_agg;
  logic       m_err;
  logic [N-1:0] m_ack;

  rcfwl_gclk_clkreqaggr_mc_if #(.NUM_CH(N)) hs ();

  rcfwl_gclk_clkreqaggr_mc #(
    .NUM_CH     (N),
    .LINGER_W   (8),
    .RST_LINGER (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_linger     (cfg_linger),
    .cfg_linger_vld (cfg_linger_vld),
    .ch_mask        (ch_mask),
    .hs             (hs.slave),
    .agg_active     (agg_active),
    .err_ack_drop   (err_ack_drop),
    .state_o        (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [N-1:0] lv_req;
    int lv;
    bit held;
    lv_req = hs.ch_clkreq & ~ch_mask;
    if (rst) begin
      m_ph = 0; m_rem = 0; m_up = 0; m_agg = 0; m_err = 0; m_ack = '0;
      return;
    end
    held  = (m_ph == 2) || (m_ph == 3);
    m_ack = (held && hs.up_clkack) ? lv_req : '0;
    if (held && !hs.up_clkack) begin
      m_err = 1;
      m_ph  = 1;
    end else begin
      case (m_ph)
        0: if (lv_req != 0) m_ph = 1;
        1: if (hs.up_clkack) m_ph = 2;
        2: if (lv_req == 0) begin
             lv = cfg_linger_vld ? int'(cfg_linger) : 8;
             if (lv > 0) begin m_ph = 3; m_rem = lv; end
             else m_ph = 4;
           end
        3: if (lv_req != 0) m_ph = 2;
           else begin
             m_rem--;
             if (m_rem == 0) m_ph = 4;
           end
        default: if (!hs.up_clkack) m_ph = 0;
      endcase
    end
    m_up  = (m_ph >= 1) && (m_ph <= 3);
    m_agg = (m_ph == 2) || (m_ph == 3);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("state_o", int'(state_o), m_ph);
    chk("up_clkreq", int'(hs.up_clkreq), int'(m_up));
    chk("ch_clkack", int'(hs.ch_clkack), int'(m_ack));
    chk("agg_active", int'(agg_active), int'(m_agg));
    chk("err_ack_drop", int'(err_ack_drop), int'(m_err));
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    int src;
    rst = 1; cfg_linger = 8'd0; cfg_linger_vld = 0; ch_mask = '0;
    hs.ch_clkreq = 4'hF; hs.up_clkack = 0;
    m_ph = 0; m_rem = 0; m_up = 0; m_agg = 0; m_err = 0; m_ack = '0;
    @(negedge clk);

    // 1: reset with all requests high
    tick(); tick(); tick();
    chk("rst_state", int'(state_o), 0);
    chk("rst_up", int'(hs.up_clkreq), 0);
    chk("rst_ack", int'(hs.ch_clkack), 0);
    rst = 0;
    tick();
    chk("rst_rel_up", int'(hs.up_clkreq), 1);

    // 2: basic handshake
    do_reset();
    hs.ch_clkreq = 4'b0001;
    tick();
    chk("hs_req_lat", int'(hs.up_clkreq), 1);
    tick();
    hs.up_clkack = 1;
    tick();
    chk("hs_active", int'(state_o), 2);
    tick();
    chk("hs_ack0", int'(hs.ch_clkack), 1);
    hs.ch_clkreq = 4'b0101;
    tick();
    chk("hs_ack2", int'(hs.ch_clkack), 5);

    // 3: linger expiry, 4 cycles
    cfg_linger = 8'd4; cfg_linger_vld = 1;
    hs.ch_clkreq = '0;
    tick();
    chk("lg_enter", int'(state_o), 3);
    chk("lg_ack0", int'(hs.ch_clkack), 0);
    tick(); tick(); tick();
    chk("lg_hold", int'(hs.up_clkreq), 1);
    tick();
    chk("lg_drop", int'(hs.up_clkreq), 0);
    chk("lg_deassert", int'(state_o), 4);
    tick();
    hs.up_clkack = 0;
    tick();
    chk("lg_idle", int'(state_o), 0);

    // 4: linger rescue
    hs.ch_clkreq = 4'b0001;
    tick();
    hs.up_clkack = 1;
    tick(); tick();
    cfg_linger = 8'd8;
    hs.ch_clkreq = '0;
    tick(); tick(); tick();
    hs.ch_clkreq = 4'b0010;
    tick();
    chk("rs_active", int'(state_o), 2);
    chk("rs_ack1", int'(hs.ch_clkack), 2);
    chk("rs_up", int'(hs.up_clkreq), 1);

    // 5: masked channel, then zero linger
    hs.up_clkack = 0;
    do_reset();
    ch_mask = 4'b0010; hs.ch_clkreq = 4'b0010;
    for (int i = 0; i < 20; i++) tick();
    chk("mk_up", int'(hs.up_clkreq), 0);
    cfg_linger = 8'd0;
    hs.ch_clkreq = 4'b0011;
    tick();
    hs.up_clkack = 1;
    tick(); tick();
    hs.ch_clkreq = 4'b0010;
    tick();
    chk("z_deassert", int'(state_o), 4);
    hs.up_clkack = 0;
    hs.ch_clkreq = '0;
    tick();

    // 6: upstream ack drop
    ch_mask = '0;
    do_reset();
    hs.ch_clkreq = 4'b1000;
    tick();
    hs.up_clkack = 1;
    tick(); tick();
    hs.up_clkack = 0;
    tick();
    chk("er_flag", int'(err_ack_drop), 1);
    chk("er_ack", int'(hs.ch_clkack), 0);
    chk("er_state", int'(state_o), 1);
    hs.up_clkack = 1;
    tick();
    hs.ch_clkreq = '0;
    tick();
    hs.up_clkack = 0;
    tick();
    chk("er_idle", int'(state_o), 0);
    chk("er_sticky", int'(err_ack_drop), 1);
    do_reset();
    chk("er_clear", int'(err_ack_drop), 0);

    // random traffic with a loosely compliant upstream source
    src = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(7) == 0) hs.ch_clkreq[b] = ~hs.ch_clkreq[b];
      ch_mask = ($urandom_range(15) == 0) ? N'($urandom) : '0;
      if ($urandom_range(40) == 0) begin
        cfg_linger = 8'($urandom_range(5));
        cfg_linger_vld = 1'($urandom);
      end
      if (m_up && src == 0 && $urandom_range(2) == 0) src = 1;
      else if (!m_up && src == 1 && $urandom_range(2) == 0) src = 0;
      else if (src == 1 && $urandom_range(99) == 0) src = 0;
      hs.up_clkack = 1'(src);
      rst = ($urandom_range(299) == 0);
      tick();
    end
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
